rr_arb_mux: RTL and testbench



---
 rtl/rr_arb_mux.sv | 114 +++++++++++
 tb/tb_rr_arb_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready round-robin arbiter into one output register.
// Ports: clk, reset (sync, active-high); in_valid/in_data/in_ready per channel
// (channel i at in_data[i*XLEN +: XLEN]); out_valid/out_data/out_sel/out_ready.
// Define RR_ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority (no ptr).
module rr_arb_mux #(
  parameter int XLEN = 32,
  parameter int N    = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_valid,
  input  logic [N*XLEN-1:0] in_data,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_data,
  output logic [SELW-1:0]   out_sel,
  input  logic              out_ready
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;

  logic            win_vld;
  logic [SELW-1:0] win_idx;
  logic [SELW:0]   cand;
  logic            load_en;
  logic            xfer;

`ifndef RR_ARB_MUX_FIXED_PRIO_EN
  logic [SELW-1:0] ptr_q, ptr_d;
`endif

  // Walk channels starting at ptr; one spare bit lets ptr+k exceed N
  // before the single subtract folds it back (no power-of-two wrap).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
      cand = (SELW+1)'(k);
`else
      cand = {1'b0, ptr_q} + (SELW+1)'(k);
      if (cand >= (SELW+1)'(N)) begin
        cand = cand - (SELW+1)'(N);
      end
`endif
      if (!win_vld && in_valid[cand[SELW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[SELW-1:0];
      end
    end
  end

  assign load_en = !valid_q || out_ready;
  assign xfer    = load_en && win_vld && !reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (win_idx == SELW'(i));
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = in_data[int'(win_idx)*XLEN +: XLEN];
      sel_d   = win_idx;
    end else if (load_en) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

`ifndef RR_ARB_MUX_FIXED_PRIO_EN
  // Priority moves only on a real transfer, so idle cycles keep it.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (win_idx == SELW'(N-1)) ? '0 : win_idx + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: vector table + scoreboard bench for rr_arb_mux (N=4),
// plus a short hand-written sequence on an N=3 instance.
module tb_rr_arb_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  logic [2:0]   v3;
  logic [95:0]  d3;
  logic [2:0]   r3;
  logic         ov3;
  logic [31:0]  od3;
  logic [1:0]   os3;

  always #5 clk = ~clk;

  rr_arb_mux #(.XLEN(32), .N(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  rr_arb_mux #(.XLEN(32), .N(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .in_valid(v3), .in_data(d3), .in_ready(r3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3),
    .out_ready(1'b1)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        ord;
    logic [31:0] base;
    logic [3:0]  rdy;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(logic rst, logic [3:0] vld, logic ord,
                     logic [31:0] base, logic [3:0] rdy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ord = ord; v.base = base; v.rdy = rdy;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] hold_d;
    logic [1:0]  hold_s;
    logic [2:0]  s3v[5];
    logic [2:0]  s3r[5];
    exp_t        e;
    int          w;

`ifndef RR_ARB_MUX_FIXED_PRIO_EN
    add(1, 4'b0000, 0, 32'h0,         4'b0000);
    add(0, 4'b0000, 0, 32'h0,         4'b0000);
    add(0, 4'b0000, 1, 32'h0,         4'b0000);
    add(0, 4'b1111, 1, 32'hA000_0000, 4'b0001);
    add(0, 4'b1111, 1, 32'hA000_0000, 4'b0010);
    add(0, 4'b1111, 1, 32'hA000_0000, 4'b0100);
    add(0, 4'b1111, 1, 32'hA000_0000, 4'b1000);
    add(0, 4'b1111, 1, 32'hA000_0000, 4'b0001);
    add(0, 4'b0100, 1, 32'hDEAD_BEED, 4'b0100);
    add(0, 4'b1111, 0, 32'h1000_0000, 4'b0000);
    add(0, 4'b1111, 0, 32'h1000_0000, 4'b0000);
    add(0, 4'b1111, 0, 32'h1000_0000, 4'b0000);
    add(0, 4'b1111, 1, 32'hB000_0000, 4'b1000);
    add(0, 4'b0000, 1, 32'h0,         4'b0000);
    add(0, 4'b0000, 0, 32'h0,         4'b0000);
    add(0, 4'b0100, 1, 32'hC000_0000, 4'b0100);
    add(0, 4'b0001, 1, 32'hC100_0000, 4'b0001);
    add(0, 4'b0110, 1, 32'hC200_0000, 4'b0010);
    add(0, 4'b1001, 1, 32'hC300_0000, 4'b1000);
    add(0, 4'b0000, 1, 32'h0,         4'b0000);
    add(0, 4'b1010, 1, 32'hC400_0000, 4'b0010);
    add(0, 4'b1111, 1, 32'hD000_0000, 4'b0100);
    add(1, 4'b1111, 1, 32'hD100_0000, 4'b0000);
    add(0, 4'b1111, 1, 32'hD200_0000, 4'b0001);
    add(0, 4'b1111, 1, 32'hD300_0000, 4'b0010);
    add(0, 4'b0000, 1, 32'h0,         4'b0000);
    add(0, 4'b0000, 0, 32'h0,         4'b0000);
    add(0, 4'b0100, 0, 32'hE000_0000, 4'b0100);
    add(0, 4'b0100, 0, 32'hE100_0000, 4'b0000);
    add(0, 4'b0000, 1, 32'h0,         4'b0000);
    add(0, 4'b0000, 0, 32'h0,         4'b0000);
    s3v = '{3'b010, 3'b001, 3'b110, 3'b110, 3'b111};
    s3r = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b001};
`else
    add(1, 4'b0000, 0, 32'h0,         4'b0000);
    add(0, 4'b0000, 1, 32'h0,         4'b0000);
    add(0, 4'b1111, 1, 32'hA000_0000, 4'b0001);
    add(0, 4'b1111, 1, 32'hA100_0000, 4'b0001);
    add(0, 4'b1111, 1, 32'hA200_0000, 4'b0001);
    add(0, 4'b1111, 0, 32'hA300_0000, 4'b0000);
    add(0, 4'b1110, 1, 32'hB000_0000, 4'b0010);
    add(0, 4'b1100, 1, 32'hB100_0000, 4'b0100);
    add(0, 4'b1000, 1, 32'hB200_0000, 4'b1000);
    add(1, 4'b1111, 1, 32'hB300_0000, 4'b0000);
    add(0, 4'b1111, 1, 32'hC000_0000, 4'b0001);
    add(0, 4'b0000, 1, 32'h0,         4'b0000);
    add(0, 4'b0000, 0, 32'h0,         4'b0000);
    s3v = '{3'b010, 3'b001, 3'b110, 3'b110, 3'b111};
    s3r = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b001};
`endif

    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    v3        = '0;
    d3        = '0;
    hold_d    = '0;
    hold_s    = '0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset     = tbl[i].rst;
      in_valid  = tbl[i].vld;
      out_ready = tbl[i].ord;
      for (int c = 0; c < 4; c++) begin
        in_data[c*32 +: 32] = tbl[i].base + 32'(c);
      end
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid),
          32'(sbq.size() != 0));
      if (sbq.size() != 0) begin
        chk($sformatf("row%0d out_data", i), out_data, sbq[0].d);
        chk($sformatf("row%0d out_sel", i), 32'(out_sel), 32'(sbq[0].s));
        if (tbl[i].ord) void'(sbq.pop_front());
      end else begin
        chk($sformatf("row%0d held data", i), out_data, hold_d);
        chk($sformatf("row%0d held sel", i), 32'(out_sel), 32'(hold_s));
      end
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      if (tbl[i].rst) begin
        sbq.delete();
        hold_d = '0;
        hold_s = '0;
      end else if (tbl[i].rdy != 0) begin
        w = 0;
        for (int c = 0; c < 4; c++) if (tbl[i].rdy[c]) w = c;
        e.d = tbl[i].base + 32'(w);
        e.s = 2'(w);
        sbq.push_back(e);
        hold_d = e.d;
        hold_s = e.s;
      end
    end

    @(negedge clk);
    reset    = 1'b1;
    in_valid = '0;
    for (int c = 0; c < 3; c++) d3[c*32 +: 32] = 32'h3000_0000 + 32'(c);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("n3 reset out_valid", 32'(ov3), 32'd0);
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) begin
        @(negedge clk);
      end
      v3 = (j < 5) ? s3v[j] : 3'b000;
      #1;
      if (j > 0) begin
        w = 0;
        for (int c = 0; c < 3; c++) if (s3r[j-1][c]) w = c;
        chk($sformatf("n3 step%0d out_valid", j), 32'(ov3), 32'd1);
        chk($sformatf("n3 step%0d out_sel", j), 32'(os3), 32'(w));
        chk($sformatf("n3 step%0d out_data", j), od3,
            32'h3000_0000 + 32'(w));
      end
      chk($sformatf("n3 step%0d in_ready", j), 32'(r3),
          32'((j < 5) ? s3r[j] : 3'b000));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
